// File: rtl/text_dma_copier_pkg.sv
// Shared types and constants for the text-card block-copy DMA.
package soc_dma_pkg;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 2048;

  // Byte enables for a full-word VGA write.
  localparam logic [3:0] VGA_WE_FULL = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } dma_state_e;

endpackage

// File: rtl/text_dma_copier_if.sv
// Control, status and bus-request signals between the I/O bank, the CPU
// arbitration logic and the copier.
interface text_dma_copier_if;
  import soc_dma_pkg::*;

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] srcAddr;
  logic [ADDR_W-1:0] dstAddr;
  logic [ADDR_W:0]   wordCount;
  logic              cpuBusy;
  logic [DATA_W-1:0] memRdata;

  logic              dmaOwn;
  logic              dmaMemEn;
  logic [ADDR_W-1:0] dmaMemAddr;
  logic              dmaVgaEn;
  logic [3:0]        dmaVgaWe;
  logic [ADDR_W-1:0] dmaVgaAddr;
  logic [DATA_W-1:0] dmaWdata;
  logic              busy;
  logic              done;
  logic              error;

  // System side: issues requests, reports CPU activity, returns read data.
  modport master (
    output start, abort, srcAddr, dstAddr, wordCount, cpuBusy, memRdata,
    input  dmaOwn, dmaMemEn, dmaMemAddr, dmaVgaEn, dmaVgaWe, dmaVgaAddr,
           dmaWdata, busy, done, error
  );

  // Copier side.
  modport slave (
    input  start, abort, srcAddr, dstAddr, wordCount, cpuBusy, memRdata,
    output dmaOwn, dmaMemEn, dmaMemAddr, dmaVgaEn, dmaVgaWe, dmaVgaAddr,
           dmaWdata, busy, done, error
  );

endinterface

// File: rtl/text_dma_busmux.sv
// Port multiplexer placed at SoC top: hands the data-memory and VGA ports
// to the copier only in cycles where it owns them.
module text_dma_busmux
  import soc_dma_pkg::*;
(
  input  logic              dma_own,
  input  logic              cpu_mem_en,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic              cpu_vga_en,
  input  logic [3:0]        cpu_vga_we,
  input  logic [ADDR_W-1:0] cpu_vga_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dma_mem_en,
  input  logic [ADDR_W-1:0] dma_mem_addr,
  input  logic              dma_vga_en,
  input  logic [3:0]        dma_vga_we,
  input  logic [ADDR_W-1:0] dma_vga_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              vga_en,
  output logic [3:0]        vga_we,
  output logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_wdata
);

  // Select the port owner for both memories.
  always_comb begin
    mem_en    = dma_own ? dma_mem_en   : cpu_mem_en;
    mem_addr  = dma_own ? dma_mem_addr : cpu_mem_addr;
    vga_en    = dma_own ? dma_vga_en   : cpu_vga_en;
    vga_we    = dma_own ? dma_vga_we   : cpu_vga_we;
    vga_addr  = dma_own ? dma_vga_addr : cpu_vga_addr;
    vga_wdata = dma_own ? dma_wdata    : cpu_wdata;
  end

endmodule

// File: rtl/text_dma_copier.sv
// Block-copy DMA from data memory to VGA text memory. Steals only cycles
// the CPU leaves idle; one word every three cycles when uncontended.
module text_dma_copier
  import soc_dma_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  text_dma_copier_if.slave bus
);

  localparam logic [ADDR_W+1:0] MEM_LIMIT = (ADDR_W+2)'(MEM_WORDS);
  localparam logic [ADDR_W:0]   ONE_WORD  = (ADDR_W+1)'(1);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              error_q, error_d;

  logic [ADDR_W+1:0] src_end;
  logic [ADDR_W+1:0] dst_end;
  logic              range_bad;
  logic              mem_grant;
  logic              vga_grant;

  // A bus phase is granted only when the CPU is not using either bank.
  assign mem_grant = (state_q == S_READ)  && !bus.cpuBusy;
  assign vga_grant = (state_q == S_WRITE) && !bus.cpuBusy;

  // Next-state, address/count update and request validation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    error_d = 1'b0;

    src_end   = {2'b00, bus.srcAddr} + {1'b0, bus.wordCount};
    dst_end   = {2'b00, bus.dstAddr} + {1'b0, bus.wordCount};
    range_bad = (src_end > MEM_LIMIT) || (dst_end > MEM_LIMIT);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (range_bad) begin
            error_d = 1'b1;
          end else if (bus.wordCount == '0) begin
            state_d = S_DONE;
          end else begin
            src_d   = bus.srcAddr;
            dst_d   = bus.dstAddr;
            rem_d   = bus.wordCount;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (bus.abort)     state_d = S_IDLE;
        else if (mem_grant) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Read data is valid here regardless of what the CPU does now.
        data_d  = bus.memRdata;
        state_d = bus.abort ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        // A write granted alongside abort still lands and is counted.
        if (vga_grant) begin
          src_d   = src_q + 1'b1;
          dst_d   = dst_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q > ONE_WORD) ? S_READ : S_DONE;
        end
        if (bus.abort) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: the data register is reset, not left uninitialised like a
    // memory, because it drives dmaWdata which must read 0 out of reset.
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  // Status and bus outputs: addresses/data straight from registers,
  // enables combinational from state and cpuBusy.
  always_comb begin
    bus.busy       = (state_q == S_READ) || (state_q == S_WAIT) ||
                     (state_q == S_WRITE);
    bus.done       = (state_q == S_DONE);
    bus.error      = error_q;
    bus.dmaOwn     = mem_grant || vga_grant;
    bus.dmaMemEn   = mem_grant;
    bus.dmaMemAddr = src_q;
    bus.dmaVgaEn   = vga_grant;
    bus.dmaVgaWe   = vga_grant ? VGA_WE_FULL : 4'b0000;
    bus.dmaVgaAddr = dst_q;
    bus.dmaWdata   = data_q;
  end

endmodule

// File: tb/tb_text_dma_copier.sv
// Bench for text_dma_copier: memories behind the SoC bus mux, a schedule
// model that predicts every read/write/done/error cycle, and randomized
// transfers with CPU contention, stray starts and aborts.
module tb_text_dma_copier;
  import soc_dma_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  text_dma_copier_if bus();

  text_dma_copier dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [ADDR_W-1:0] cpu_mem_addr;
  logic              m_mem_en;
  logic [ADDR_W-1:0] m_mem_addr;
  logic              m_vga_en;
  logic [3:0]        m_vga_we;
  logic [ADDR_W-1:0] m_vga_addr;
  logic [DATA_W-1:0] m_vga_wdata;

  text_dma_busmux mux (
    .dma_own      (bus.dmaOwn),
    .cpu_mem_en   (bus.cpuBusy),
    .cpu_mem_addr (cpu_mem_addr),
    .cpu_vga_en   (1'b0),
    .cpu_vga_we   (4'b0000),
    .cpu_vga_addr ('0),
    .cpu_wdata    ('0),
    .dma_mem_en   (bus.dmaMemEn),
    .dma_mem_addr (bus.dmaMemAddr),
    .dma_vga_en   (bus.dmaVgaEn),
    .dma_vga_we   (bus.dmaVgaWe),
    .dma_vga_addr (bus.dmaVgaAddr),
    .dma_wdata    (bus.dmaWdata),
    .mem_en       (m_mem_en),
    .mem_addr     (m_mem_addr),
    .vga_en       (m_vga_en),
    .vga_we       (m_vga_we),
    .vga_addr     (m_vga_addr),
    .vga_wdata    (m_vga_wdata)
  );

  logic [DATA_W-1:0] dmem [MEM_WORDS];
  logic [DATA_W-1:0] vmem [MEM_WORDS] = '{default: '0};
  logic [DATA_W-1:0] exp_vga [MEM_WORDS] = '{default: '0};

  int checks   = 0;
  int failures = 0;

  // Synchronous-read data memory and byte-writable VGA memory.
  always @(posedge clk) begin
    if (m_mem_en) bus.memRdata <= dmem[m_mem_addr];
    if (m_vga_en)
      for (int b = 0; b < 4; b++)
        if (m_vga_we[b]) vmem[m_vga_addr][8*b +: 8] <= m_vga_wdata[8*b +: 8];
  end

  function automatic int idx_of(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return i;
    return -1;
  endfunction

  // mode: 0 = no CPU activity, 1 = random contention/stray starts/aborts,
  // 2 = CPU busy in cycles 1,2 and 6. abort_wr / rst_wait: word index whose
  // WRITE gets an abort / whose WAIT gets a reset (-1 = none).
  task automatic run_xfer(input string name, input int src, input int dst,
                          input int cnt, input int mode, input int abort_wr,
                          input int rst_wait);
    int  rd_c[$];
    int  wr_c[$];
    int  stall_c[$];
    int  t, r, w, done_c, err_c, stop_c, last_c, ir, iw, lo, hi;
    bit  err, cut_abort, cut_rst, e_mem, e_vga, e_busy;
    err = (src + cnt > MEM_WORDS) || (dst + cnt > MEM_WORDS);
    t = 1;
    if (!err) begin
      for (int k = 0; k < cnt; k++) begin
        r = (mode == 1) ? int'($urandom_range(0, 2)) :
            (mode == 2 && k == 0) ? 2 : (mode == 2 && k == 1) ? 1 : 0;
        w = (mode == 1) ? int'($urandom_range(0, 2)) : 0;
        for (int s = 0; s < r; s++) stall_c.push_back(t + s);
        rd_c.push_back(t + r);
        for (int s = 0; s < w; s++) stall_c.push_back(t + r + 2 + s);
        wr_c.push_back(t + r + 2 + w);
        t = t + r + w + 3;
      end
    end
    done_c    = err ? -1 : ((cnt == 0) ? 1 : t);
    err_c     = err ? 1 : -1;
    cut_abort = !err && abort_wr >= 0 && abort_wr < cnt;
    cut_rst   = !err && rst_wait >= 0 && rst_wait < cnt;
    stop_c    = -1;
    if (cut_abort) begin stop_c = wr_c[abort_wr];     done_c = -1; end
    if (cut_rst)   begin stop_c = rd_c[rst_wait] + 1; done_c = -1; end
    last_c = ((stop_c > 0) ? stop_c : (done_c > 0) ? done_c : 1) + 2;

    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      ir     = idx_of(rd_c, c);
      iw     = idx_of(wr_c, c);
      e_mem  = (ir >= 0) && (stop_c < 0 || c <= stop_c);
      e_vga  = (iw >= 0) && (stop_c < 0 || c <= stop_c);
      e_busy = (done_c > 0 && c >= 1 && c < done_c) ||
               (stop_c > 0 && c >= 1 && c <= stop_c);

      if (ir >= 0 || iw >= 0)           bus.cpuBusy = 1'b0;
      else if (idx_of(stall_c, c) >= 0) bus.cpuBusy = 1'b1;
      else bus.cpuBusy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.start = (c == 0) || (mode == 1 && e_busy && $urandom_range(0, 3) == 0);
      if (c == 0) begin
        bus.srcAddr   = ADDR_W'(src);
        bus.dstAddr   = ADDR_W'(dst);
        bus.wordCount = (ADDR_W+1)'(cnt);
      end else begin
        bus.srcAddr   = ADDR_W'($urandom);
        bus.dstAddr   = ADDR_W'($urandom);
        bus.wordCount = (ADDR_W+1)'($urandom_range(0, 64));
      end
      bus.abort = (cut_abort && c == stop_c) ||
                  (mode == 1 && (c == done_c || c == last_c) && $urandom_range(0, 1) == 1);
      reset = !(cut_rst && c == stop_c);
      cpu_mem_addr = ADDR_W'($urandom);
      #1;

      checks++; if (bus.dmaMemEn !== e_mem) begin failures++;
        $display("FAIL %s c=%0d dmaMemEn got=%b exp=%b", name, c, bus.dmaMemEn, e_mem); end
      checks++; if (bus.dmaVgaEn !== e_vga) begin failures++;
        $display("FAIL %s c=%0d dmaVgaEn got=%b exp=%b", name, c, bus.dmaVgaEn, e_vga); end
      checks++; if (bus.dmaVgaWe !== (e_vga ? 4'hF : 4'h0)) begin failures++;
        $display("FAIL %s c=%0d dmaVgaWe got=%h exp_en=%b", name, c, bus.dmaVgaWe, e_vga); end
      checks++; if (bus.dmaOwn !== (e_mem || e_vga) || (bus.dmaOwn && bus.cpuBusy)) begin failures++;
        $display("FAIL %s c=%0d dmaOwn got=%b exp=%b cpuBusy=%b", name, c, bus.dmaOwn, e_mem || e_vga, bus.cpuBusy); end
      checks++; if (bus.busy !== e_busy) begin failures++;
        $display("FAIL %s c=%0d busy got=%b exp=%b", name, c, bus.busy, e_busy); end
      checks++; if (bus.done !== (c == done_c)) begin failures++;
        $display("FAIL %s c=%0d done got=%b exp=%b", name, c, bus.done, c == done_c); end
      checks++; if (bus.error !== (c == err_c)) begin failures++;
        $display("FAIL %s c=%0d error got=%b exp=%b", name, c, bus.error, c == err_c); end
      if (e_mem) begin
        checks++; if (bus.dmaMemAddr !== ADDR_W'(src + ir)) begin failures++;
          $display("FAIL %s c=%0d dmaMemAddr got=%h exp=%h", name, c, bus.dmaMemAddr, ADDR_W'(src + ir)); end
      end
      if (e_vga) begin
        checks++; if (bus.dmaVgaAddr !== ADDR_W'(dst + iw)) begin failures++;
          $display("FAIL %s c=%0d dmaVgaAddr got=%h exp=%h", name, c, bus.dmaVgaAddr, ADDR_W'(dst + iw)); end
        checks++; if (bus.dmaWdata !== dmem[src + iw]) begin failures++;
          $display("FAIL %s c=%0d dmaWdata got=%h exp=%h", name, c, bus.dmaWdata, dmem[src + iw]); end
        exp_vga[dst + iw] = dmem[src + iw];
      end
      if (cut_rst && c == stop_c + 1) begin
        checks++;
        if (bus.dmaMemAddr !== '0 || bus.dmaVgaAddr !== '0 || bus.dmaWdata !== '0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
          failures++;
          $display("FAIL %s post_reset_outputs got mem=%h vga=%h wd=%h busy=%b exp all 0",
                   name, bus.dmaMemAddr, bus.dmaVgaAddr, bus.dmaWdata, bus.busy);
        end
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    reset     = 1'b1;

    @(negedge clk);
    lo = (dst > 0) ? dst - 1 : 0;
    hi = (dst + cnt < MEM_WORDS) ? dst + cnt : MEM_WORDS - 1;
    for (int a = lo; a <= hi; a++) begin
      checks++; if (vmem[a] !== exp_vga[a]) begin failures++;
        $display("FAIL %s vga[%0h] got=%h exp=%h", name, a, vmem[a], exp_vga[a]); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.start = 1'b1; bus.abort = 1'b0; bus.cpuBusy = 1'b0;
    bus.srcAddr = '0; bus.dstAddr = '0; bus.wordCount = (ADDR_W+1)'(4);
    cpu_mem_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.error, bus.dmaOwn, bus.dmaMemEn, bus.dmaVgaEn} !== 6'b0 ||
        bus.dmaVgaWe !== 4'h0 || bus.dmaMemAddr !== '0 || bus.dmaVgaAddr !== '0 ||
        bus.dmaWdata !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b err=%b own=%b we=%h wd=%h exp all 0",
               bus.busy, bus.done, bus.error, bus.dmaOwn, bus.dmaVgaWe, bus.dmaWdata);
    end
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL reset_priority busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_basic();
    run_xfer("basic", 'h010, 'h000, 4, 0, -1, -1);
  endtask

  task automatic test_contention();
    run_xfer("contention", 'h010, 'h000, 4, 2, -1, -1);
  endtask

  task automatic test_boundary();
    run_xfer("bound_ok",   'h7FC, $urandom_range(0, 2044), 4, 0, -1, -1);
    run_xfer("bound_src",  'h7FD, 'h000, 4, 0, -1, -1);
    run_xfer("bound_dst",  'h100, 'h7FF, 2, 0, -1, -1);
    run_xfer("full_2048",  'h000, 'h000, 2048, 0, -1, -1);
  endtask

  task automatic test_zero();
    run_xfer("zero", $urandom_range(0, 2047), $urandom_range(0, 2047), 0, 0, -1, -1);
  endtask

  task automatic test_abort();
    run_xfer("abort",       'h020, 'h040, 8, 0, 2, -1);
    run_xfer("after_abort", 'h030, 'h060, 3, 0, -1, -1);
    run_xfer("abort_rand",  'h050, 'h080, 8, 1, 5, -1);
  endtask

  task automatic test_reset_wait();
    run_xfer("rst_wait",       'h100, 'h200, 6, 1, -1, 2);
    run_xfer("after_rst_wait", 'h110, 'h210, 3, 0, -1, -1);
  endtask

  task automatic test_random();
    int s, d, n;
    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(0, 20);
      s = $urandom_range(0, 2047 - n);
      d = $urandom_range(0, 2047 - n);
      if (i % 4 == 3) s = $urandom_range(2040, 2047);
      run_xfer("random", s, d, n, 1, -1, -1);
    end
  endtask

  initial begin
    for (int a = 0; a < MEM_WORDS; a++) dmem[a] = $urandom;
    test_reset();
    test_basic();
    test_contention();
    test_boundary();
    test_zero();
    test_abort();
    test_reset_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
